// File: rtl/max_uint_pkg.sv
// Shared types and constants for the streaming unsigned max/argmax reducer.
package max_uint_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CMP  = 2'd2,
    EMIT = 2'd3
  } state_t;

  localparam int IMPL_PARALLEL = 0;
  localparam int IMPL_SERIAL   = 1;

  // Never returns less than 1 so a one-bit operand still gets a counter bit.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/gt_uint_serial.sv
// Bit-serial MSB-first unsigned greater-than: a > b, decided by the first differing bit.
module gt_uint_serial (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic a_bit,
  input  logic b_bit,
  input  logic done,
  output logic gt
);

  logic decided_q, decided_d;
  logic gt_q, gt_d;
  logic decided_now;

  // start forgets any earlier comparison, so the first bit always counts.
  assign decided_now = start ? 1'b0 : decided_q;
  assign gt          = decided_now ? gt_q : (a_bit & ~b_bit);

  always_comb begin
    decided_d = decided_now;
    gt_d      = gt_q;
    if (!decided_now && (a_bit != b_bit)) begin
      decided_d = 1'b1;
      gt_d      = a_bit;
    end
    if (done) begin
      decided_d = 1'b0;
      gt_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
    end else begin
      decided_q <= decided_d;
      gt_q      <= gt_d;
    end
  end

endmodule

// File: rtl/max_uint_stream.sv
// Streaming unsigned maximum / first-occurrence argmax / element count over a
// valid-ready frame, with a word-parallel or bit-serial comparator.
module max_uint_stream
  import max_uint_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0,
  parameter int IDX_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W-1:0] out_count,
  output logic             out_ovf
);

  localparam int                BIT_W   = clog2(WIDTH);
  localparam logic [BIT_W-1:0] BIT_MSB = BIT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   cur_max_q, cur_max_d;
  logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   cand_q, cand_d;
  logic [IDX_W-1:0]   cand_idx_q, cand_idx_d;
  logic               last_q, last_d;
  logic [BIT_W-1:0]   bit_q, bit_d;

  logic               in_xfer;
  logic               out_xfer;
  logic [IDX_W-1:0]   cnt_inc;
  logic               cnt_wrap;
  logic               ser_gt;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign cnt_inc  = cnt_q + 1'b1;
  assign cnt_wrap = (cnt_inc == '0);

  generate
    if (IMPL_TYPE == IMPL_SERIAL) begin : g_serial
      logic cmp_start;
      logic cmp_done;
      assign cmp_start = (state_q == CMP) && (bit_q == BIT_MSB);
      assign cmp_done  = (state_q == CMP) && (bit_q == '0);

      gt_uint_serial u_gt (
        .clk   (clk),
        .rst_n (rst_n),
        .start (cmp_start),
        .a_bit (cand_q[bit_q]),
        .b_bit (cur_max_q[bit_q]),
        .done  (cmp_done),
        .gt    (ser_gt)
      );
    end else begin : g_parallel
      assign ser_gt = 1'b0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          state_d = in_last ? EMIT : ACC;
        end
      end
      ACC: begin
        if (in_xfer) begin
          if (IMPL_TYPE == IMPL_SERIAL) begin
            state_d = CMP;
          end else if (in_last) begin
            state_d = EMIT;
          end
        end
      end
      CMP: begin
        if (bit_q == '0) begin
          state_d = last_q ? EMIT : ACC;
        end
      end
      EMIT: begin
        if (out_xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; ready is forced low while reset is held.
  always_comb begin
    in_ready  = rst_n && ((state_q == IDLE) || (state_q == ACC));
    out_valid = (state_q == EMIT);
  end

  assign out_max   = cur_max_q;
  assign out_idx   = cur_idx_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

  always_comb begin
    cur_max_d  = cur_max_q;
    cur_idx_d  = cur_idx_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    cand_d     = cand_q;
    cand_idx_d = cand_idx_q;
    last_d     = last_q;
    bit_d      = bit_q;
    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          cur_max_d = in_data;
          cur_idx_d = '0;
          cnt_d     = IDX_W'(1);
          ovf_d     = 1'b0;
        end
      end
      ACC: begin
        if (in_xfer) begin
          cnt_d      = cnt_inc;
          ovf_d      = ovf_q | cnt_wrap;
          cand_d     = in_data;
          cand_idx_d = cnt_q;
          last_d     = in_last;
          if (IMPL_TYPE == IMPL_SERIAL) begin
            bit_d = BIT_MSB;
          end else if (in_data > cur_max_q) begin
            // Strict compare keeps the earliest index on ties.
            cur_max_d = in_data;
            cur_idx_d = cnt_q;
          end
        end
      end
      CMP: begin
        if (bit_q != '0) begin
          bit_d = bit_q - 1'b1;
        end else if (ser_gt) begin
          cur_max_d = cand_q;
          cur_idx_d = cand_idx_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_max_q  <= '0;
      cur_idx_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      cand_q     <= '0;
      cand_idx_q <= '0;
      last_q     <= 1'b0;
      bit_q      <= '0;
    end else begin
      cur_max_q  <= cur_max_d;
      cur_idx_q  <= cur_idx_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      cand_q     <= cand_d;
      cand_idx_q <= cand_idx_d;
      last_q     <= last_d;
      bit_q      <= bit_d;
    end
  end

endmodule
